// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg
// Shared definitions for the codec configuration sequencer: field widths of
// one table entry and of the I2C word, the sequencer state encoding, the
// default codec init table and a saturating counter helper.
package codec_cfg_pkg;

    localparam int REG_ADDR_W = 7;
    localparam int REG_DATA_W = 9;
    localparam int DEV_ADDR_W = 8;
    localparam int ENTRY_W    = REG_ADDR_W + REG_DATA_W;
    localparam int TX_W       = DEV_ADDR_W + ENTRY_W;

    localparam int DEFAULT_NUM_REGS = 6;

    // Entry i sits in bits [16i+15:16i] as {reg_addr[6:0], reg_data[8:0]}.
    // Entry 0 is the right-most word.
    localparam logic [DEFAULT_NUM_REGS*ENTRY_W-1:0] DEFAULT_TABLE = {
        16'h0217,   // 5: reg 1, data 0x017
        16'h0017,   // 4: reg 0, data 0x017
        16'h0C39,   // 3: reg 6, data 0x039
        16'h1201,   // 2: reg 9, data 0x001
        16'h0E42,   // 1: reg 7, data 0x042
        16'h0804    // 0: reg 4, data 0x004
    };

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [6:0] sat_inc7(input logic [6:0] v);
        return (v == 7'h7F) ? v : v + 7'd1;
    endfunction

endpackage

// File: rtl/codec_config_seq_if.sv
// codec_config_seq_if
// Transfer handshake between the configuration sequencer and the I2C master.
//   tx_data  : {DEV_ADDR, reg_addr, reg_data}, stable for the whole transfer
//   tx_start : one-cycle transfer request
//   tx_done  : one-cycle pulse from the I2C master at transfer end
//   tx_ack   : valid with tx_done, 1 = all three bytes ACKed
// Modport master is the requesting side (the sequencer); modport slave is the
// I2C engine that executes the transfer.
interface codec_config_seq_if;
    import codec_cfg_pkg::*;

    logic [TX_W-1:0] tx_data;
    logic            tx_start;
    logic            tx_done;
    logic            tx_ack;

    modport master (output tx_data, output tx_start, input tx_done, input tx_ack);
    modport slave  (input tx_data, input tx_start, output tx_done, output tx_ack);

endinterface

// File: rtl/codec_cfg_rom.sv
// codec_cfg_rom
// Combinational lookup of one 16-bit {reg_addr, reg_data} entry from the
// packed TABLE parameter.
//   idx   : entry index; indices at or beyond NUM_REGS read as zero
//   entry : selected table word
module codec_cfg_rom
    import codec_cfg_pkg::*;
#(
    parameter int                          NUM_REGS = DEFAULT_NUM_REGS,
    parameter logic [NUM_REGS*ENTRY_W-1:0] TABLE    = DEFAULT_TABLE
) (
    input  logic [5:0]         idx,
    output logic [ENTRY_W-1:0] entry
);

    // Table word select, guarded so an out-of-range index never reads past the table.
    always_comb begin
        entry = {ENTRY_W{1'b0}};
        if (int'(idx) < NUM_REGS) begin
            entry = TABLE[int'(idx)*ENTRY_W +: ENTRY_W];
        end else begin
            entry = {ENTRY_W{1'b0}};
        end
    end

endmodule

// File: rtl/codec_config_seq.sv
// codec_config_seq
// Walks a table of codec register writes and hands each one to an I2C master,
// resending an entry up to MAX_RETRY times after a NACK.
//   inclk   : system clock
//   rst     : asynchronous active-low reset
//   go      : single-cycle request to (re)run the table, honoured only in IDLE
//   bus     : transfer handshake to the I2C master (master modport)
//   busy    : sequence in progress (LOAD/START/WAIT/CHECK)
//   rdy     : last run finished with every entry ACKed
//   err     : last run aborted on an entry that exhausted its retries
//   err_idx : index of the failing entry
//   ack_cnt : entries ACKed in the current or last run, saturating at 127
module codec_config_seq
    import codec_cfg_pkg::*;
#(
    parameter logic [7:0]                  DEV_ADDR   = 8'h34,
    parameter int                          NUM_REGS   = DEFAULT_NUM_REGS,
    parameter int                          MAX_RETRY  = 2,
    parameter logic [NUM_REGS*ENTRY_W-1:0] TABLE      = DEFAULT_TABLE,
    parameter bit                          AUTO_START = 1'b1
) (
    input  logic                inclk,
    input  logic                rst,
    input  logic                go,
    codec_config_seq_if.master  bus,
    output logic                busy,
    output logic                rdy,
    output logic                err,
    output logic [5:0]          err_idx,
    output logic [6:0]          ack_cnt
);

    localparam logic [5:0] LAST_IDX    = 6'(NUM_REGS - 1);
    localparam logic [2:0] MAX_RETRY_W = 3'(MAX_RETRY);

    state_t             state_r;
    logic [5:0]         idx_r;
    logic [2:0]         retry_r;
    logic               ack_smp_r;
    logic               auto_pend_r;
    logic [TX_W-1:0]    tx_data_r;
    logic               tx_start_r;
    logic               busy_r;
    logic               rdy_r;
    logic               err_r;
    logic [5:0]         err_idx_r;
    logic [6:0]         ack_cnt_r;
    logic [ENTRY_W-1:0] rom_entry_s;

    codec_cfg_rom #(
        .NUM_REGS (NUM_REGS),
        .TABLE    (TABLE)
    ) u_rom (
        .idx   (idx_r),
        .entry (rom_entry_s)
    );

    // Sequencer FSM; every output is a register updated on the transition
    // into the state where it must be visible.
    always_ff @(posedge inclk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            idx_r       <= 6'd0;
            retry_r     <= 3'd0;
            ack_smp_r   <= 1'b0;
            auto_pend_r <= AUTO_START;
            tx_data_r   <= {TX_W{1'b0}};
            tx_start_r  <= 1'b0;
            busy_r      <= 1'b0;
            rdy_r       <= 1'b0;
            err_r       <= 1'b0;
            err_idx_r   <= 6'd0;
            ack_cnt_r   <= 7'd0;
        end else begin
            tx_start_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // auto_pend_r covers the single self-start after reset
                    if (go || auto_pend_r) begin
                        auto_pend_r <= 1'b0;
                        idx_r       <= 6'd0;
                        retry_r     <= 3'd0;
                        ack_cnt_r   <= 7'd0;
                        rdy_r       <= 1'b0;
                        err_r       <= 1'b0;
                        err_idx_r   <= 6'd0;
                        busy_r      <= 1'b1;
                        state_r     <= LOAD;
                    end
                end
                LOAD: begin
                    // tx_data is written only here, so it holds through retries
                    tx_data_r  <= {DEV_ADDR, rom_entry_s};
                    tx_start_r <= 1'b1;
                    state_r    <= START;
                end
                START: begin
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (bus.tx_done) begin
                        ack_smp_r <= bus.tx_ack;
                        state_r   <= CHECK;
                    end
                end
                CHECK: begin
                    if (ack_smp_r) begin
                        ack_cnt_r <= sat_inc7(ack_cnt_r);
                        retry_r   <= 3'd0;
                        if (idx_r == LAST_IDX) begin
                            rdy_r   <= 1'b1;
                            busy_r  <= 1'b0;
                            state_r <= DONE;
                        end else begin
                            idx_r   <= idx_r + 6'd1;
                            state_r <= LOAD;
                        end
                    end else if (retry_r < MAX_RETRY_W) begin
                        // resend the word already held in tx_data_r
                        retry_r    <= retry_r + 3'd1;
                        tx_start_r <= 1'b1;
                        state_r    <= START;
                    end else begin
                        err_r     <= 1'b1;
                        err_idx_r <= idx_r;
                        busy_r    <= 1'b0;
                        state_r   <= FAIL;
                    end
                end
                DONE, FAIL: begin
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_data  = tx_data_r;
    assign bus.tx_start = tx_start_r;
    assign busy         = busy_r;
    assign rdy          = rdy_r;
    assign err          = err_r;
    assign err_idx      = err_idx_r;
    assign ack_cnt      = ack_cnt_r;

endmodule

// File: tb/tb_codec_config_seq.sv
// tb_codec_config_seq
// Scoreboard bench: a reference model turns a per-entry NACK plan into the
// expected sequence of transfer words and the expected end-of-run status; a
// monitor pops and compares on every tx_start. dut_a uses defaults, dut_b is a
// one-entry, go-started variant.
`timescale 1ns/1ps
module tb_codec_config_seq;
    import codec_cfg_pkg::*;

    localparam int N    = 6;
    localparam int MAXR = 2;
    localparam logic [23:0] GOLDEN [N] = '{24'h340804, 24'h340E42, 24'h341201,
                                           24'h340C39, 24'h340017, 24'h340217};
    localparam logic [23:0] GOLDEN_B = 24'h341234;

    logic inclk = 1'b0;
    logic rst   = 1'b0;
    logic go_a  = 1'b0;
    logic go_b  = 1'b0;
    logic       busy_a, rdy_a, err_a, busy_b, rdy_b, err_b;
    logic [5:0] err_idx_a, err_idx_b;
    logic [6:0] ack_cnt_a, ack_cnt_b;

    codec_config_seq_if bus_a ();
    codec_config_seq_if bus_b ();

    always #5 inclk = ~inclk;

    codec_config_seq dut_a (
        .inclk (inclk), .rst (rst), .go (go_a), .bus (bus_a),
        .busy (busy_a), .rdy (rdy_a), .err (err_a),
        .err_idx (err_idx_a), .ack_cnt (ack_cnt_a)
    );

    codec_config_seq #(
        .NUM_REGS (1), .AUTO_START (1'b0), .TABLE (16'h1234)
    ) dut_b (
        .inclk (inclk), .rst (rst), .go (go_b), .bus (bus_b),
        .busy (busy_b), .rdy (rdy_b), .err (err_b),
        .err_idx (err_idx_b), .ack_cnt (ack_cnt_b)
    );

    logic [23:0] exp_q[$];
    logic [23:0] exp_b_q[$];
    bit          ack_q[$];
    int  checks = 0;
    int  errors = 0;
    int  starts_a = 0;
    int  exp_cnt, exp_eidx;
    bit  exp_rdy, exp_err;
    int  plan[N];
    int  spur_req = 0;
    int  spur_done = 0;
    int  force_delay = 0;
    logic [23:0] mon_e, mon_eb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: entry e is NACKed plan[e] times before its ACK; more
    // NACKs than MAX_RETRY aborts the run on that entry.
    task automatic prepare();
        exp_q.delete();
        ack_q.delete();
        exp_cnt  = 0;
        exp_rdy  = 1'b1;
        exp_err  = 1'b0;
        exp_eidx = 0;
        for (int e = 0; e < N; e++) begin
            int tries;
            bit ok;
            ok    = (plan[e] <= MAXR);
            tries = ok ? plan[e] + 1 : MAXR + 1;
            for (int t = 0; t < tries; t++) begin
                exp_q.push_back(GOLDEN[e]);
                ack_q.push_back(ok && (t == tries - 1));
            end
            if (!ok) begin
                exp_rdy  = 1'b0;
                exp_err  = 1'b1;
                exp_eidx = e;
                break;
            end
            exp_cnt++;
        end
    endtask

    task automatic clear_plan();
        for (int e = 0; e < N; e++) plan[e] = 0;
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (busy_a !== level && n < 3000) begin
            @(negedge inclk);
            n++;
        end
        if (busy_a !== level) begin
            checks++;
            errors++;
            $display("FAIL %s: busy stayed %b, expected %b", name, busy_a, level);
        end
    endtask

    task automatic check_result(input string tag);
        check({tag, "_rdy"},     32'(rdy_a),     32'(exp_rdy));
        check({tag, "_err"},     32'(err_a),     32'(exp_err));
        check({tag, "_err_idx"}, 32'(err_idx_a), 32'(exp_eidx));
        check({tag, "_ack_cnt"}, 32'(ack_cnt_a), 32'(exp_cnt));
        check({tag, "_left"},    32'(exp_q.size()), 32'd0);
    endtask

    task automatic pulse_go_a();
        @(negedge inclk);
        go_a = 1'b1;
        @(negedge inclk);
        go_a = 1'b0;
    endtask

    task automatic run_go(input string tag, input bit poke);
        pulse_go_a();
        wait_busy(1'b1, {tag, "_start"});
        if (poke) begin
            repeat ($urandom_range(1, 6)) @(negedge inclk);
            // go while busy must not disturb the run
            if (busy_a) begin
                go_a = 1'b1;
                @(negedge inclk);
                go_a = 1'b0;
            end
        end
        wait_busy(1'b0, {tag, "_end"});
        check_result(tag);
    endtask

    // Monitor for dut_a: every tx_start must match the next expected word.
    initial begin
        forever begin
            @(negedge inclk);
            if (bus_a.tx_start === 1'b1) begin
                starts_a++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start_a: got tx_data 0x%0h, expected no transfer", bus_a.tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("tx_data_a", 32'(bus_a.tx_data), 32'(mon_e));
                end
            end
        end
    end

    // Monitor for dut_b.
    initial begin
        forever begin
            @(negedge inclk);
            if (bus_b.tx_start === 1'b1) begin
                if (exp_b_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start_b: got tx_data 0x%0h, expected no transfer", bus_b.tx_data);
                end else begin
                    mon_eb = exp_b_q.pop_front();
                    check("tx_data_b", 32'(bus_b.tx_data), 32'(mon_eb));
                end
            end
        end
    end

    // I2C master model for dut_a: answers each tx_start after a random delay
    // with the next planned ack bit; drops a pending answer on reset.
    initial begin
        bit pend;
        bit pend_ack;
        int cnt;
        pend = 1'b0;
        pend_ack = 1'b0;
        cnt = 0;
        bus_a.tx_done = 1'b0;
        bus_a.tx_ack  = 1'b0;
        forever begin
            @(negedge inclk);
            bus_a.tx_done = 1'b0;
            if (!rst) begin
                pend = 1'b0;
            end else if (pend) begin
                if (cnt == 0) begin
                    bus_a.tx_done = 1'b1;
                    bus_a.tx_ack  = pend_ack;
                    pend = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (spur_done != spur_req) begin
                bus_a.tx_done = 1'b1;
                bus_a.tx_ack  = 1'b1;
                spur_done++;
            end
            if (rst && bus_a.tx_start === 1'b1) begin
                pend     = 1'b1;
                pend_ack = (ack_q.size() != 0) ? ack_q.pop_front() : 1'b1;
                cnt      = (force_delay != 0) ? force_delay - 1 : $urandom_range(0, 3);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        bus_b.tx_done = 1'b0;
        bus_b.tx_ack  = 1'b0;
        clear_plan();
        prepare();
        #1;
        check("rst_tx_start", 32'(bus_a.tx_start), 32'd0);
        check("rst_tx_data",  32'(bus_a.tx_data),  32'd0);
        check("rst_busy",     32'(busy_a),  32'd0);
        check("rst_rdy",      32'(rdy_a),   32'd0);
        check("rst_ack_cnt",  32'(ack_cnt_a), 32'd0);
        repeat (3) @(negedge inclk);
        rst = 1'b1;

        // auto-started run, all entries ACKed
        base = starts_a;
        wait_busy(1'b1, "auto_start");
        wait_busy(1'b0, "auto_end");
        check_result("all_ack");
        // still in the DONE cycle: this go must be ignored
        go_a = 1'b1;
        @(negedge inclk);
        go_a = 1'b0;
        repeat (20) @(negedge inclk);
        check("done_go_busy", 32'(busy_a), 32'd0);
        check("all_ack_starts", 32'(starts_a - base), 32'd6);

        // spurious tx_done in IDLE
        spur_req++;
        repeat (10) @(negedge inclk);
        check("spur_ack_cnt", 32'(ack_cnt_a), 32'd6);
        check("spur_busy",    32'(busy_a),    32'd0);
        check("spur_rdy",     32'(rdy_a),     32'd1);

        // entry 2 NACKed once
        clear_plan();
        plan[2] = 1;
        prepare();
        base = starts_a;
        run_go("nack2", 1'b0);
        check("nack2_starts", 32'(starts_a - base), 32'd7);

        // entry 3 never ACKs
        clear_plan();
        plan[3] = 3;
        prepare();
        base = starts_a;
        run_go("nack3", 1'b0);
        repeat (10) @(negedge inclk);
        check("nack3_starts", 32'(starts_a - base), 32'd6);

        // reset during WAIT of entry 1, then auto restart from entry 0
        clear_plan();
        prepare();
        exp_q.push_front(GOLDEN[1]);
        exp_q.push_front(GOLDEN[0]);
        ack_q.push_front(1'b1);
        ack_q.push_front(1'b1);
        force_delay = 8;
        base = starts_a;
        pulse_go_a();
        n = 0;
        while (starts_a < base + 2 && n < 500) begin
            @(negedge inclk);
            n++;
        end
        check("rst_mid_reached", 32'(starts_a - base), 32'd2);
        @(negedge inclk);
        #2;
        rst = 1'b0;
        #1;
        check("rst_mid_tx_start", 32'(bus_a.tx_start), 32'd0);
        check("rst_mid_tx_data",  32'(bus_a.tx_data),  32'd0);
        check("rst_mid_busy",     32'(busy_a),    32'd0);
        check("rst_mid_ack_cnt",  32'(ack_cnt_a), 32'd0);
        check("rst_mid_err",      32'(err_a),     32'd0);
        repeat (3) @(negedge inclk);
        rst = 1'b1;
        force_delay = 0;
        wait_busy(1'b1, "restart_start");
        wait_busy(1'b0, "restart_end");
        check_result("restart");

        // randomized NACK plans, with go poked while busy
        for (int r = 0; r < 8; r++) begin
            for (int e = 0; e < N; e++) begin
                plan[e] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            prepare();
            run_go("rand", 1'b1);
        end

        // one-entry, go-started instance
        check("b_idle_busy", 32'(busy_b), 32'd0);
        check("b_idle_rdy",  32'(rdy_b),  32'd0);
        exp_b_q.push_back(GOLDEN_B);
        @(negedge inclk);
        go_b = 1'b1;
        @(negedge inclk);
        go_b = 1'b0;
        n = 0;
        while (bus_b.tx_start !== 1'b1 && n < 50) begin
            @(negedge inclk);
            n++;
        end
        check("b_start_seen", 32'(bus_b.tx_start), 32'd1);
        go_b = 1'b1;
        @(negedge inclk);
        go_b = 1'b0;
        @(negedge inclk);
        bus_b.tx_done = 1'b1;
        bus_b.tx_ack  = 1'b1;
        @(negedge inclk);
        bus_b.tx_done = 1'b0;
        n = 0;
        while (busy_b !== 1'b0 && n < 50) begin
            @(negedge inclk);
            n++;
        end
        check("b_rdy",     32'(rdy_b),     32'd1);
        check("b_err",     32'(err_b),     32'd0);
        check("b_ack_cnt", 32'(ack_cnt_b), 32'd1);
        repeat (20) @(negedge inclk);
        check("b_busy_after", 32'(busy_b), 32'd0);
        check("b_left",       32'(exp_b_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
